// File: rtl/demux_1x2_32_reg_pkg.sv
// Shared processor-wide definitions for the registered 1:2 demultiplexer.
// Provides the data width and the select encoding used to steer words.
package demux_1x2_32_reg_pkg;

    localparam int DATA_W = 32;

    localparam logic SEL_Y0 = 1'b0;
    localparam logic SEL_Y1 = 1'b1;

endpackage

// File: rtl/demux_1x2_32_reg_out_slot.sv
// One-entry output register with a valid/ready handshake.
// The slot can take a new word on the same edge that the held word drains.
module out_slot
    import demux_1x2_32_reg_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill,
    input  logic [WIDTH-1:0] data,
    input  logic             yk_ready,
    output logic [WIDTH-1:0] yk,
    output logic             yk_valid,
    output logic             slot_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Fill wins over drain so a refill on the draining edge leaves no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (fill) begin
            r_valid <= 1'b1;
            r_data  <= data;
        end else if (r_valid && yk_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign slot_ready = !r_valid || yk_ready;
    assign yk         = r_data;
    assign yk_valid   = r_valid;

endmodule

// File: rtl/demux_1x2_32_reg.sv
// Registered 1:2 demultiplexer: steers op to slot y1 or y0 according to s.
// Each slot stalls independently; op_ready reflects only the selected slot.
module demux_1x2_32_reg
    import demux_1x2_32_reg_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op,
    input  logic             s,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready
);

    logic             w_accept;
    logic [1:0]       w_fill;
    logic [1:0]       w_ready_in;
    logic [1:0]       w_slot_ready;
    logic [1:0]       w_valid;
    logic [WIDTH-1:0] w_y [2];

    assign w_ready_in[SEL_Y1] = y1_ready;
    assign w_ready_in[SEL_Y0] = y0_ready;

    assign op_ready = w_slot_ready[s];
    assign w_accept = op_valid && op_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign w_fill[gi] = w_accept && (s == 1'(gi));

            out_slot #(
                .WIDTH(WIDTH)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .fill      (w_fill[gi]),
                .data      (op),
                .yk_ready  (w_ready_in[gi]),
                .yk        (w_y[gi]),
                .yk_valid  (w_valid[gi]),
                .slot_ready(w_slot_ready[gi])
            );
        end
    endgenerate

    assign y1       = w_y[SEL_Y1];
    assign y1_valid = w_valid[SEL_Y1];
    assign y0       = w_y[SEL_Y0];
    assign y0_valid = w_valid[SEL_Y0];

endmodule

// File: doc/demux_1x2_32_reg.md
Name: demux_1x2_32_reg

Overview:
- Registered 1-to-2 demultiplexer: routes one 32-bit source word to one of two destination ports, selected by s.
- Inverse of the 2:1 datapath select. Used where one result (e.g. ALU or memory read data) must be steered to one of two consumers, such as the register-file write-back path vs. the store-data path.
- Each destination has a one-entry holding register with a valid/ready handshake, so one consumer can stall without blocking the other.

Parameters:
- WIDTH, 32, data width of op, y1 and y0.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- op  input  WIDTH  source data word.
- s  input  1  destination select: 1 selects y1, 0 selects y0.
- op_valid  input  1  op and s are valid this cycle.
- op_ready  output  1  block accepts op this cycle (combinational).
- y1  output  WIDTH  destination-1 data (registered).
- y1_valid  output  1  y1 holds an undelivered word.
- y1_ready  input  1  destination-1 consumer accepts y1.
- y0  output  WIDTH  destination-0 data (registered).
- y0_valid  output  1  y0 holds an undelivered word.
- y0_ready  input  1  destination-0 consumer accepts y0.

Behaviour:
- Clock and reset: single clock domain. rst is sampled only on the rising edge of clk and is active-high.
- Reset values: y1=0, y0=0, y1_valid=0, y0_valid=0. op_ready evaluates to 1 after reset because both slots are empty.
- Slot k (k=1 selects y1, k=0 selects y0) is a one-entry register holding valid_k and data_k.
- Drain: a slot drains on a cycle when yk_valid && yk_ready.
- Ready: op_ready = !valid[s] || yk_ready[s]. This is a combinational path from the selected yk_ready and from s. The unselected port's ready has no effect on op_ready.
- Accept: the block accepts op on a cycle when op_valid && op_ready. On the next edge, data[s] <= op and valid[s] <= 1.
- Latency: the word appears at y[s] with y[s]_valid=1 one cycle after acceptance. No combinational path from op to any y.
- Throughput: one word per cycle, including back-to-back words to the same slot while its consumer holds ready=1.
- Drain without refill: valid_k <= 0. data_k holds its last value; it is don't-care while invalid.
- Drain and fill on the same edge, same slot: the new word replaces the old one and valid_k stays 1. No bubble, no loss.
- Fill one slot while the other drains: the two slots are fully independent.
- Stall: while yk_valid=1 && yk_ready=0, yk and yk_valid are held stable, as the handshake requires. A word sent to the stalled slot sees op_ready=0, while the other slot can still accept.
- Source rules: the source may change op or s freely while op_valid=0. If the source holds op_valid=1 while op_ready=0, it may also change s; the block never commits a word that was not accepted.
- Reset mid-operation: rst=1 clears both valids on that edge and discards any pending words, even if a transfer was accepted that cycle. rst takes priority over every other update.
- No internal state machine beyond the two valid bits. States per slot are EMPTY and FULL:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on a drain without refill.
  - FULL -> FULL on a drain with refill, or on a stall.

Decomposition:
- Shared package (processor-wide defs):
  - DATA_W = 32.
  - Select encoding constants SEL_Y0 = 1'b0, SEL_Y1 = 1'b1.
- Sub-module out_slot (parameter WIDTH): one-entry register stage with fill, data, yk_ready, yk, yk_valid and a slot_ready output. It is instantiated twice.
- The top level holds only the select steering and the op_ready mux.

Test Plan:
- Reset check: assert rst for 2 cycles with op_valid=1, s=1, op=32'hDEAD_BEEF → y1=y0=0, both valids 0 during reset. After release, op_ready=1.
- Single route: op=32'h1234_5678, s=1, op_valid=1 for one cycle with y1_ready=0 → next cycle y1=32'h1234_5678, y1_valid=1, y0_valid=0. Then raise y1_ready → y1_valid=0 on the following cycle.
- Back-to-back same slot at full rate: with y0_ready=1, stream op=1,2,3,4 and s=0 on consecutive cycles → y0 shows 1,2,3,4 on consecutive cycles, y0_valid=1 throughout, and op_ready stays 1.
- Independent stall: with y1_ready=0 and slot 1 full (32'hAAAA_AAAA), send s=1 op=32'hBBBB_BBBB → op_ready=0 and y1 stays 32'hAAAA_AAAA. Then switch to s=0 op=32'hCCCC_CCCC → op_ready=1 and y0=32'hCCCC_CCCC one cycle later.
- Simultaneous drain and fill: slot 1 holds 32'h0000_0011 and y1_ready=1 while op=32'h0000_0022, s=1 is accepted → next cycle y1=32'h0000_0022, y1_valid=1, with no gap and no loss.
- Mid-operation reset: both slots full (y1=32'h5, y0=32'h6) and a word is being accepted when rst=1 for one cycle → both valids are 0 the next cycle and neither 32'h5 nor 32'h6 is later presented.
